// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants and small helpers for the fetch stage and its neighbours.
package rv_pipe_pkg;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 32;
   localparam int CNT_W   = 16;
   localparam int REG_W   = 5;

   localparam logic [PC_W-1:0]    PC_STEP   = PC_W'(4);
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_ADVANCE,
      FETCH_HOLD,
      FETCH_REDIRECT
   } fetch_op_e;

   // Instruction fetches are word aligned, so the low address bits are dropped.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == '1) ? value : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: flags an instruction that reads the register a preceding load
// has not yet written back.
module hazard_unit
   import rv_pipe_pkg::*;
(
   input  logic               mem_read,
   input  logic [REG_W-1:0]   ex_rd,
   input  logic [INSTR_W-1:0] instr,
   output logic               stop
);

   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;

   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign stop = mem_read && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch/decode latch, load-use stall,
// branch redirect/flush and saturating stall/flush event counters.
module if_stage
   import rv_pipe_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               idex_MemRead,
   input  logic [REG_W-1:0]   idex_rd,
   output logic [PC_W-1:0]    Curr_Pc,
   output logic [INSTR_W-1:0] Curr_Instr,
   output logic               stop,
   output logic               branch_reset,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   logic [PC_W-1:0] pc;
   fetch_op_e       op;

   hazard_unit u_hazard (
      .mem_read (idex_MemRead),
      .ex_rd    (idex_rd),
      .instr    (Curr_Instr),
      .stop     (stop)
   );

   assign imem_addr    = pc;
   assign branch_reset = branch_taken;

   // A redirect squashes the stalled instruction anyway, so it outranks the stall.
   always_comb begin
      op = FETCH_ADVANCE;
      if (branch_taken) begin
         op = FETCH_REDIRECT;
      end else if (stop) begin
         op = FETCH_HOLD;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values and the block order cannot change the result.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc         <= '0;
         Curr_Pc    <= '0;
         Curr_Instr <= NOP_INSTR;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         case (op)
            FETCH_REDIRECT: begin
               pc         <= align_pc(branch_target);
               Curr_Pc    <= '0;
               Curr_Instr <= NOP_INSTR;
               flush_cnt  <= sat_inc(flush_cnt);
            end
            FETCH_HOLD: begin
               stall_cnt  <= sat_inc(stall_cnt);
            end
            default: begin
               pc         <= pc + PC_STEP;
               Curr_Pc    <= pc;
               Curr_Instr <= imem_rdata;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run, with
// expected register state queued at drive time and compared after each clock.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic        idex_MemRead;
   logic [4:0]  idex_rd;
   logic [7:0]  Curr_Pc;
   logic [31:0] Curr_Instr;
   logic        stop;
   logic        branch_reset;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   typedef struct {
      logic [7:0]  pc;
      logic [7:0]  cpc;
      logic [31:0] instr;
      logic [15:0] stall;
      logic [15:0] flush;
   } exp_t;

   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_pc;
   logic [7:0]  m_cpc;
   logic [31:0] m_instr;
   logic [15:0] m_stall;
   logic [15:0] m_flush;
   logic        m_valid = 1'b0;

   if_stage dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .idex_MemRead  (idex_MemRead),
      .idex_rd       (idex_rd),
      .Curr_Pc       (Curr_Pc),
      .Curr_Instr    (Curr_Instr),
      .stop          (stop),
      .branch_reset  (branch_reset),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   always #5 clk = ~clk;

   // Every word reads rs1=20 and rs2=5, except address 0x10 which holds add x2,x1,x2.
   function automatic logic [31:0] mem_word(input logic [7:0] addr);
      if (addr == 8'h10) return 32'h0020_8133;
      return {addr, 8'h5A, 16'h0013};
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // One clock: drive inputs at negedge, check combinational outputs, update the
   // reference model, queue its expected state, then compare after the posedge.
   task automatic drive(input logic rst, input logic bt, input logic [7:0] tgt,
                        input logic mr, input logic [4:0] rd);
      exp_t e;
      logic es;
      @(negedge clk);
      reset         = rst;
      branch_taken  = bt;
      branch_target = tgt;
      idex_MemRead  = mr;
      idex_rd       = rd;
      #1;
      es = mr && (rd != 5'd0) && ((rd == m_instr[19:15]) || (rd == m_instr[24:20]));
      check("branch_reset", {31'd0, branch_reset}, {31'd0, bt});
      if (m_valid) begin
         check("imem_addr_pre", {24'd0, imem_addr}, {24'd0, m_pc});
         check("stop_pre", {31'd0, stop}, {31'd0, es});
      end
      if (!rst) begin
         m_pc = 8'h00; m_cpc = 8'h00; m_instr = 32'h13; m_stall = 16'd0; m_flush = 16'd0;
         m_valid = 1'b1;
      end else if (bt) begin
         m_pc    = {tgt[7:2], 2'b00};
         m_cpc   = 8'h00;
         m_instr = 32'h13;
         if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
      end else if (es) begin
         if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      end else begin
         m_cpc   = m_pc;
         m_instr = mem_word(m_pc);
         m_pc    = m_pc + 8'd4;
      end
      if (m_valid) begin
         e.pc = m_pc; e.cpc = m_cpc; e.instr = m_instr; e.stall = m_stall; e.flush = m_flush;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (m_valid) begin
         if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check("imem_addr", {24'd0, imem_addr}, {24'd0, e.pc});
            check("Curr_Pc", {24'd0, Curr_Pc}, {24'd0, e.cpc});
            check("Curr_Instr", Curr_Instr, e.instr);
            check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.stall});
            check("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.flush});
         end
      end
   endtask

   initial begin
      reset = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; idex_MemRead = 1'b0; idex_rd = 5'd0;

      // Two reset cycles, then straight-line fetch from address 0.
      drive(1'b0, 1'b0, 8'h00, 1'b0, 5'd0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 5'd0);
      check("rst_addr", {24'd0, imem_addr}, 32'h0);
      check("rst_instr", Curr_Instr, 32'h0000_0013);
      check("rst_stop", {31'd0, stop}, 32'd0);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
      check("seq_addr_4", {24'd0, imem_addr}, 32'h4);
      check("seq_cpc_0", {24'd0, Curr_Pc}, 32'h0);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
      check("seq_addr_8", {24'd0, imem_addr}, 32'h8);
      check("seq_cpc_4", {24'd0, Curr_Pc}, 32'h4);
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
      check("add_loaded", Curr_Instr, 32'h0020_8133);

      // Load-use on rs2 stalls; the same stimulus with rd=x0 does not.
      drive(1'b1, 1'b0, 8'h00, 1'b1, 5'd2);
      check("stall_stop", {31'd0, stop}, 32'd1);
      check("stall_pc", {24'd0, imem_addr}, 32'h14);
      check("stall_instr", Curr_Instr, 32'h0020_8133);
      check("stall_cnt_1", {16'd0, stall_cnt}, 32'd1);
      drive(1'b1, 1'b0, 8'h00, 1'b1, 5'd0);
      check("x0_cpc", {24'd0, Curr_Pc}, 32'h14);
      check("x0_pc", {24'd0, imem_addr}, 32'h18);

      // Branch and stall together: redirect wins, target low bits dropped.
      drive(1'b1, 1'b1, 8'h43, 1'b1, 5'd20);
      check("br_pc", {24'd0, imem_addr}, 32'h40);
      check("br_instr", Curr_Instr, 32'h0000_0013);
      check("br_flush", {16'd0, flush_cnt}, 32'd1);
      check("br_stall", {16'd0, stall_cnt}, 32'd1);
      check("br_reset_out", {31'd0, branch_reset}, 32'd1);

      // PC wrap from 0xFC to 0x00.
      drive(1'b1, 1'b1, 8'hFE, 1'b0, 5'd0);
      check("wrap_pre", {24'd0, imem_addr}, 32'hFC);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
      check("wrap_pc", {24'd0, imem_addr}, 32'h00);
      check("wrap_cpc", {24'd0, Curr_Pc}, 32'hFC);

      // Reset during a stall, then during a redirect.
      drive(1'b1, 1'b0, 8'h00, 1'b1, 5'd5);
      check("stall2_stop", {31'd0, stop}, 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 5'd5);
      check("rst_stall_pc", {24'd0, imem_addr}, 32'h0);
      check("rst_stall_cpc", {24'd0, Curr_Pc}, 32'h0);
      check("rst_stall_instr", Curr_Instr, 32'h0000_0013);
      check("rst_stall_scnt", {16'd0, stall_cnt}, 32'd0);
      check("rst_stall_fcnt", {16'd0, flush_cnt}, 32'd0);
      check("rst_stall_stop", {31'd0, stop}, 32'd0);
      drive(1'b0, 1'b1, 8'h80, 1'b0, 5'd0);
      check("rst_br_pc", {24'd0, imem_addr}, 32'h0);
      check("rst_br_fcnt", {16'd0, flush_cnt}, 32'd0);

      // Randomized mix of redirects, load-use hazards and occasional resets.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] rd;
         case ($urandom_range(0, 3))
            0:       rd = 5'd0;
            1:       rd = 5'd5;
            2:       rd = 5'd20;
            default: rd = 5'($urandom_range(0, 31));
         endcase
         drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
